// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: streams a program image into the CPU's byte RAM, verifies
// the trailing checksum byte and releases the CPU with its start PC.
module cpu_prog_loader #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic [31:0]       pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [7:0]          sum_q, sum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic [31:0]         pc_init_q, pc_init_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                count_ok;
    logic                start_ok;
    logic                handshake;
    logic [7:0]          check_sum;

    // Handshake qualifiers; in_ready is decoded from the state register only.
    always_comb begin
        count_ok  = (byte_count != '0) && (byte_count[1:0] == 2'b00);
        start_ok  = (state_q == IDLE) && start && count_ok;
        in_ready  = (state_q == LOAD) || (state_q == CHECK);
        handshake = in_valid && in_ready;
        check_sum = sum_q + in_data;
    end

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cur_d       = cur_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        pc_init_d   = pc_init_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_ok) begin
                        base_d      = base_addr;
                        cur_d       = base_addr;
                        remaining_d = byte_count;
                        sum_d       = 8'h00;
                        err_d       = 1'b0;
                        cpu_hold_d  = 1'b1;
                        state_d     = LOAD;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cur_q;
                    mem_wdata_d = in_data;
                    cur_d       = cur_q + ADDR_W'(1);
                    sum_d       = sum_q + in_data;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (handshake) begin
                    if (check_sum == 8'h00) begin
                        err_d      = 1'b0;
                        cpu_hold_d = 1'b0;
                        pc_init_d  = {{(32-ADDR_W){1'b0}}, base_q};
                    end else begin
                        err_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cur_q       <= '0;
            remaining_q <= '0;
            sum_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b1;
            pc_init_q   <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cur_q       <= cur_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            pc_init_q   <= pc_init_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Output drive; an accepted start re-holds the CPU in the same cycle.
    always_comb begin
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        cpu_hold  = cpu_hold_q | start_ok;
        pc_init   = pc_init_q;
        busy      = (state_q != IDLE);
        done      = done_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb_cpu_prog_loader: directed self-checking bench for cpu_prog_loader.
module tb_cpu_prog_loader;

    logic        clka = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  byte_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic [31:0] pc_init;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] img [0:8];
    logic [8:0] logAddr [$];
    logic [7:0] logData [$];
    int         logCyc  [$];
    logic [7:0] ramModel [0:511];
    int         cyc = 0;

    cpu_prog_loader #(.ADDR_W(9), .LEN_W(10)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .pc_init    (pc_init),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 10 ns clock
    always #5 clka = ~clka;

    // Cycle counter used to stamp RAM writes
    always @(posedge clka) cyc <= cyc + 1;

    // RAM write monitor, sampled away from the active edge
    always @(negedge clka) begin
        if (mem_we) begin
            logAddr.push_back(mem_addr);
            logData.push_back(mem_wdata);
            logCyc.push_back(cyc);
            ramModel[mem_addr] = mem_wdata;
        end
    end

    // Hard watchdog so the bench can never hang
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse start with the given base and count on the next falling edge
    task automatic applyStimulus(input logic [8:0] base, input logic [9:0] count);
        @(negedge clka);
        start      = 1'b1;
        base_addr  = base;
        byte_count = count;
    endtask

    // Stream img[0..nBytes-1]; optional random gaps and a start pulse mid-stream
    task automatic sendStream(input int nBytes, input bit gaps, input int midStartAt);
        int idx   = 0;
        int guard = 0;
        while (idx < nBytes && guard < 400) begin
            @(negedge clka);
            guard++;
            if (midStartAt >= 0 && idx == midStartAt) begin
                start      = 1'b1;
                base_addr  = 9'd0;
                byte_count = 10'd4;
            end else begin
                start = 1'b0;
            end
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = img[idx];
                if (in_ready) idx++;
            end
        end
        @(negedge clka);
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("stream_sent", idx, nBytes);
    endtask

    task automatic waitDone(input int bound);
        for (int i = 0; i < bound && !done; i++) @(negedge clka);
        checkOutput("done_seen", done, 1);
    endtask

    task automatic checkWrites(input string tag, input int first, input int n,
                               input int base);
        checkOutput({tag, "_nwr"}, logAddr.size(), first + n);
        for (int i = 0; i < n && first + i < logAddr.size(); i++) begin
            checkOutput({tag, "_addr"}, logAddr[first + i], (base + i) % 512);
            checkOutput({tag, "_data"}, logData[first + i], img[i]);
        end
    endtask

    task automatic setImage(input logic [7:0] b0, input logic [7:0] ck);
        for (int i = 0; i < 8; i++) img[i] = b0 + 8'(i);
        img[8] = ck;
    endtask

    initial begin
        int first;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        byte_count = '0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        for (int i = 0; i < 512; i++) ramModel[i] = 8'h00;

        // Reset values
        #12;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_cpu_hold", cpu_hold, 1);
        checkOutput("rst_pc_init", pc_init, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        @(negedge clka);
        rst_n = 1'b1;

        // Test 1: base 0, bytes 01..08, checksum DC
        $display("[TB] test 1: clean load at base 0");
        setImage(8'h01, 8'hDC);
        first = logAddr.size();
        applyStimulus(9'd0, 10'd8);
        sendStream(9, 1'b0, -1);
        waitDone(20);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_cpu_hold", cpu_hold, 0);
        checkOutput("t1_pc_init", pc_init, 0);
        @(negedge clka);
        checkOutput("t1_done_pulse", done, 0);
        checkOutput("t1_busy", busy, 0);
        checkWrites("t1", first, 8, 0);
        for (int i = 1; i < 8 && first + i < logCyc.size(); i++)
            checkOutput("t1_consecutive", logCyc[first + i] - logCyc[first], i);

        // Test 2: wrap past 511, checksum for 10..17 is 64
        $display("[TB] test 2: wrapping load at base 508");
        setImage(8'h10, 8'h64);
        first = logAddr.size();
        applyStimulus(9'd508, 10'd8);
        sendStream(9, 1'b0, -1);
        waitDone(20);
        checkOutput("t2_err", err, 0);
        checkOutput("t2_cpu_hold", cpu_hold, 0);
        checkOutput("t2_pc_init", pc_init, 32'd508);
        @(negedge clka);
        checkWrites("t2", first, 8, 508);
        checkOutput("t2_word508", {ramModel[511], ramModel[510], ramModel[509], ramModel[508]},
                    32'h13121110);

        // Test 3: bad checksum keeps CPU held and previous PC
        $display("[TB] test 3: bad checksum");
        setImage(8'h01, 8'h00);
        first = logAddr.size();
        applyStimulus(9'd0, 10'd8);
        #1;
        checkOutput("t3_hold_same_cycle", cpu_hold, 1);
        sendStream(9, 1'b0, -1);
        waitDone(20);
        checkOutput("t3_err", err, 1);
        checkOutput("t3_cpu_hold", cpu_hold, 1);
        checkOutput("t3_pc_init", pc_init, 32'd508);
        @(negedge clka);
        checkOutput("t3_err_sticky", err, 1);
        checkWrites("t3", first, 8, 0);

        // Test 4: invalid counts 6 and 0
        $display("[TB] test 4: invalid byte counts");
        first = logAddr.size();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(9'd0, (k == 0) ? 10'd6 : 10'd0);
            @(negedge clka);
            start = 1'b0;
            checkOutput("t4_done", done, 1);
            checkOutput("t4_err", err, 1);
            checkOutput("t4_busy", busy, 0);
            checkOutput("t4_in_ready", in_ready, 0);
            checkOutput("t4_cpu_hold", cpu_hold, 1);
            @(negedge clka);
            checkOutput("t4_done_pulse", done, 0);
            checkOutput("t4_busy_after", busy, 0);
        end
        checkOutput("t4_no_writes", logAddr.size(), first);

        // Test 5: random valid gaps, start pulsed mid-load; A0..A7 needs E4
        $display("[TB] test 5: stalls and ignored start");
        setImage(8'hA0, 8'hE4);
        first = logAddr.size();
        applyStimulus(9'd100, 10'd8);
        sendStream(9, 1'b1, 3);
        waitDone(20);
        checkOutput("t5_err", err, 0);
        checkOutput("t5_cpu_hold", cpu_hold, 0);
        checkOutput("t5_pc_init", pc_init, 32'd100);
        @(negedge clka);
        checkWrites("t5", first, 8, 100);
        checkOutput("t5_idle", busy, 0);

        // Test 6: reset after 3 bytes, then a fresh clean load
        $display("[TB] test 6: reset mid-load");
        setImage(8'h01, 8'hDC);
        first = logAddr.size();
        applyStimulus(9'd0, 10'd8);
        sendStream(3, 1'b0, -1);
        checkOutput("t6_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_in_ready", in_ready, 0);
        checkOutput("t6_rst_mem_we", mem_we, 0);
        checkOutput("t6_rst_cpu_hold", cpu_hold, 1);
        checkOutput("t6_rst_pc_init", pc_init, 0);
        checkOutput("t6_rst_err", err, 0);
        checkOutput("t6_rst_mem_addr", mem_addr, 0);
        checkOutput("t6_rst_mem_wdata", mem_wdata, 0);
        checkOutput("t6_partial_writes", logAddr.size(), first + 3);
        @(negedge clka);
        rst_n = 1'b1;
        first = logAddr.size();
        applyStimulus(9'd0, 10'd8);
        sendStream(9, 1'b0, -1);
        waitDone(20);
        checkOutput("t6_err", err, 0);
        checkOutput("t6_cpu_hold", cpu_hold, 0);
        checkOutput("t6_pc_init", pc_init, 0);
        @(negedge clka);
        checkWrites("t6", first, 8, 0);
        checkOutput("t6_word0", {ramModel[3], ramModel[2], ramModel[1], ramModel[0]},
                    32'h04030201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
